adc_capture_sequencer: RTL and testbench

ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

---
 rtl/adc_capture_sequencer.sv | 148 ++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// Capture-session sequencer for the ADC capture block: arm, trigger wait, burst capture, holdoff.
// Optional trigger-wait timeout is compiled in with `define ADC_SEQ_TIMEOUT_EN.
module adc_capture_sequencer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           cfg_limiter,
    input  logic [15:0]          cfg_trigger_level,
    input  logic [15:0]          cfg_bursts,
    input  logic [CNT_WIDTH-1:0] cfg_holdoff,
    input  logic [CNT_WIDTH-1:0] cfg_timeout,
    input  logic [15:0]          cur_adc,
    input  logic                 adc_tvalid,
    input  logic                 adc_tlast,
    output logic                 adc_reset_trigger,
    output logic                 adc_reset_max_sum,
    output logic [7:0]           adc_limiter,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [15:0]          bursts_done,
    output logic [2:0]           state
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARM       = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    logic [2:0]           state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [15:0]          bursts_next;
    logic                 timeout_next;
    logic                 accept;
    logic [15:0]          trig_level_q;
    logic [15:0]          bursts_q;
    logic [CNT_WIDTH-1:0] holdoff_q;

`ifdef ADC_SEQ_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] timeout_q;
`else
    logic                 unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
`endif

    assign accept = (state == ST_IDLE) && start && !abort;

    always_comb begin
        state_next   = state;
        cnt_next     = '0;
        bursts_next  = bursts_done;
        timeout_next = timeout;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_ARM;
                    bursts_next  = '0;
                    timeout_next = 1'b0;
                end
            end
            ST_ARM: begin
                if (cnt == CNT_WIDTH'(1)) state_next = ST_WAIT_TRIG;
                else                      cnt_next   = cnt + CNT_WIDTH'(1);
            end
            ST_WAIT_TRIG: begin
                if (cur_adc > trig_level_q) begin
                    state_next = ST_CAPTURE;
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if ((timeout_q != '0) && (cnt == timeout_q - CNT_WIDTH'(1))) begin
                    state_next   = ST_DONE;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
`endif
            end
            ST_CAPTURE: begin
                if (adc_tvalid && adc_tlast) begin
                    if (bursts_done != 16'hFFFF) bursts_next = bursts_done + 16'd1;
                    // A zero holdoff bypasses HOLDOFF entirely.
                    if ((bursts_q != '0) && (bursts_next == bursts_q)) state_next = ST_DONE;
                    else if (holdoff_q == '0)                          state_next = ST_WAIT_TRIG;
                    else                                               state_next = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cnt == holdoff_q - CNT_WIDTH'(1)) state_next = ST_WAIT_TRIG;
                else                                  cnt_next   = cnt + CNT_WIDTH'(1);
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Abort discards anything decided above in the same cycle, including a final tlast.
        if (abort && (state != ST_IDLE)) begin
            state_next   = ST_IDLE;
            cnt_next     = '0;
            bursts_next  = bursts_done;
            timeout_next = timeout;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bursts_done       <= '0;
            timeout           <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            adc_reset_trigger <= 1'b0;
            adc_reset_max_sum <= 1'b0;
            adc_limiter       <= '0;
            trig_level_q      <= '0;
            bursts_q          <= '0;
            holdoff_q         <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
            timeout_q         <= '0;
`endif
        end else begin
            state             <= state_next;
            cnt               <= cnt_next;
            bursts_done       <= bursts_next;
            timeout           <= timeout_next;
            busy              <= (state_next != ST_IDLE);
            done              <= (state_next == ST_DONE);
            adc_reset_trigger <= (state_next == ST_CAPTURE);
            adc_reset_max_sum <= (state_next == ST_ARM);
            if (accept) begin
                adc_limiter  <= cfg_limiter;
                trig_level_q <= cfg_trigger_level;
                bursts_q     <= cfg_bursts;
                holdoff_q    <= cfg_holdoff;
`ifdef ADC_SEQ_TIMEOUT_EN
                timeout_q    <= cfg_timeout;
`endif
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Self-checking bench for adc_capture_sequencer: vector table, directed corner sequences,
// and randomized sessions predicted from session parameters.
module tb_adc_capture_sequencer;

    localparam int CW = 16;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic          aclk = 1'b0;
    logic          areset, start, abort;
    logic [7:0]    cfg_limiter;
    logic [15:0]   cfg_trigger_level, cfg_bursts;
    logic [CW-1:0] cfg_holdoff, cfg_timeout;
    logic [15:0]   cur_adc;
    logic          adc_tvalid, adc_tlast;
    logic          adc_reset_trigger, adc_reset_max_sum, busy, done, timeout;
    logic [7:0]    adc_limiter;
    logic [15:0]   bursts_done;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_bad = 0;

    adc_capture_sequencer #(.CNT_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .cfg_limiter(cfg_limiter), .cfg_trigger_level(cfg_trigger_level),
        .cfg_bursts(cfg_bursts), .cfg_holdoff(cfg_holdoff), .cfg_timeout(cfg_timeout),
        .cur_adc(cur_adc), .adc_tvalid(adc_tvalid), .adc_tlast(adc_tlast),
        .adc_reset_trigger(adc_reset_trigger), .adc_reset_max_sum(adc_reset_max_sum),
        .adc_limiter(adc_limiter), .busy(busy), .done(done), .timeout(timeout),
        .bursts_done(bursts_done), .state(state)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string       name;
        logic        rst, st, ab, tv, tl;
        logic [15:0] adc;
        logic [2:0]  e_state;
        logic        e_done;
        logic [15:0] e_bd;
        logic [7:0]  e_lim;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input string n, input logic rst, input logic st, input logic ab,
                           input logic tv, input logic tl, input logic [15:0] adc,
                           input logic [2:0] es, input logic ed, input logic [15:0] ebd,
                           input logic [7:0] elim);
        vec_t v;
        v.name = n; v.rst = rst; v.st = st; v.ab = ab; v.tv = tv; v.tl = tl; v.adc = adc;
        v.e_state = es; v.e_done = ed; v.e_bd = ebd; v.e_lim = elim;
        tbl.push_back(v);
    endtask

    // Expected output word: derived outputs follow directly from the state they describe.
    function automatic logic [23:0] pack_exp(input logic [2:0] st, input logic dn,
                                             input logic to, input logic [15:0] bd);
        return {st, (st != S_IDLE), (st == S_CAP), (st == S_ARM), dn, to, bd};
    endfunction

    function automatic logic [23:0] pack_act();
        return {state, busy, adc_reset_trigger, adc_reset_max_sum, done, timeout, bursts_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [2:0] st, input logic dn,
                              input logic to, input logic [15:0] bd);
        chk(name, {8'h00, pack_act()}, {8'h00, pack_exp(st, dn, to, bd)});
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; abort = 1'b0; adc_tvalid = 1'b0; adc_tlast = 1'b0; areset = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cycles, input string name);
        int n = 0;
        while (state !== st && n < max_cycles) begin
            tick();
            n++;
        end
        chk(name, 32'(state), 32'(st));
    endtask

    task automatic rand_session(input int idx);
        int          nb, ho, d, c;
        logic [15:0] lvl, bd;
        logic [7:0]  lim;
        nb  = $urandom_range(0, 4);
        ho  = $urandom_range(0, 5);
        lvl = 16'($urandom_range(0, 16'hFFFE));
        lim = 8'($urandom);
        cfg_bursts = 16'(nb); cfg_holdoff = CW'(ho); cfg_trigger_level = lvl;
        cfg_limiter = lim; cfg_timeout = '0;
        bd = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out($sformatf("rnd%0d_arm1", idx), S_ARM, 1'b0, 1'b0, bd);
        chk($sformatf("rnd%0d_lim", idx), 32'(adc_limiter), 32'(lim));
        // Config must be latched: scrambling it mid-session must not matter.
        cfg_bursts = 16'($urandom); cfg_holdoff = CW'($urandom);
        cfg_trigger_level = 16'($urandom); cfg_limiter = 8'($urandom);
        cur_adc = 16'($urandom);
        tick();
        expect_out($sformatf("rnd%0d_arm2", idx), S_ARM, 1'b0, 1'b0, bd);
        cur_adc = 16'($urandom);
        tick();
        expect_out($sformatf("rnd%0d_wait", idx), S_WAIT, 1'b0, 1'b0, bd);
        for (int b = 0; b < 4; b++) begin
            d = $urandom_range(0, 4);
            for (int k = 0; k < d; k++) begin
                cur_adc = 16'($urandom_range(0, int'(lvl)));
                adc_tvalid = 1'($urandom); adc_tlast = 1'($urandom);
                tick();
                expect_out($sformatf("rnd%0d_hold_wait", idx), S_WAIT, 1'b0, 1'b0, bd);
            end
            cur_adc = 16'($urandom_range(int'(lvl) + 1, 16'hFFFF));
            adc_tvalid = 1'b0; adc_tlast = 1'b0;
            tick();
            expect_out($sformatf("rnd%0d_trig", idx), S_CAP, 1'b0, 1'b0, bd);
            c = $urandom_range(0, 4);
            for (int k = 0; k < c; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    adc_tvalid = 1'($urandom); adc_tlast = 1'b0;
                end else begin
                    adc_tvalid = 1'b0; adc_tlast = 1'b1;
                end
                cur_adc = 16'($urandom);
                tick();
                expect_out($sformatf("rnd%0d_cap", idx), S_CAP, 1'b0, 1'b0, bd);
            end
            adc_tvalid = 1'b1; adc_tlast = 1'b1;
            abort = ($urandom_range(0, 7) == 0) || (nb == 0 && b == 3);
            tick();
            adc_tvalid = 1'b0; adc_tlast = 1'b0;
            if (abort) begin
                abort = 1'b0;
                expect_out($sformatf("rnd%0d_abort", idx), S_IDLE, 1'b0, 1'b0, bd);
                return;
            end
            bd = (bd == 16'hFFFF) ? bd : bd + 16'd1;
            if (nb != 0 && int'(bd) == nb) begin
                expect_out($sformatf("rnd%0d_done", idx), S_DONE, 1'b1, 1'b0, bd);
                tick();
                expect_out($sformatf("rnd%0d_idle", idx), S_IDLE, 1'b0, 1'b0, bd);
                return;
            end
            if (ho == 0) begin
                expect_out($sformatf("rnd%0d_nohold", idx), S_WAIT, 1'b0, 1'b0, bd);
            end else begin
                expect_out($sformatf("rnd%0d_hold", idx), S_HOLD, 1'b0, 1'b0, bd);
                for (int k = 1; k < ho; k++) begin
                    cur_adc = 16'($urandom);
                    tick();
                    expect_out($sformatf("rnd%0d_hold_n", idx), S_HOLD, 1'b0, 1'b0, bd);
                end
                cur_adc = 16'($urandom);
                tick();
                expect_out($sformatf("rnd%0d_hold_exit", idx), S_WAIT, 1'b0, 1'b0, bd);
            end
        end
    endtask

    initial begin
        int   n;
        logic rt_seen, left_wait;

        quiet();
        cur_adc = '0;
        cfg_limiter = 8'h5A; cfg_trigger_level = 16'h00FF; cfg_bursts = 16'd1;
        cfg_holdoff = '0; cfg_timeout = '0;

        //       name              rst st ab tv tl adc       state   dn bd     lim
        add_vec("reset",           1, 0, 0, 0, 0, 16'h0000, S_IDLE, 0, 16'd0, 8'h00);
        add_vec("idle",            0, 0, 0, 0, 0, 16'h0000, S_IDLE, 0, 16'd0, 8'h00);
        add_vec("tlast_in_idle",   0, 0, 0, 1, 1, 16'h0000, S_IDLE, 0, 16'd0, 8'h00);
        add_vec("start",           0, 1, 0, 0, 0, 16'h0000, S_ARM,  0, 16'd0, 8'h5A);
        add_vec("arm2_start_busy", 0, 1, 0, 0, 0, 16'h0100, S_ARM,  0, 16'd0, 8'h5A);
        add_vec("enter_wait",      0, 0, 0, 0, 0, 16'h0000, S_WAIT, 0, 16'd0, 8'h5A);
        add_vec("equal_level",     0, 0, 0, 0, 0, 16'h00FF, S_WAIT, 0, 16'd0, 8'h5A);
        add_vec("tlast_in_wait",   0, 0, 0, 1, 1, 16'h0000, S_WAIT, 0, 16'd0, 8'h5A);
        add_vec("trigger",         0, 0, 0, 0, 0, 16'h0100, S_CAP,  0, 16'd0, 8'h5A);
        add_vec("tvalid_only",     0, 0, 0, 1, 0, 16'h0000, S_CAP,  0, 16'd0, 8'h5A);
        add_vec("tlast_no_valid",  0, 0, 0, 0, 1, 16'h0000, S_CAP,  0, 16'd0, 8'h5A);
        add_vec("final_tlast",     0, 0, 0, 1, 1, 16'h0000, S_DONE, 1, 16'd1, 8'h5A);
        add_vec("back_idle",       0, 0, 0, 0, 0, 16'h0000, S_IDLE, 0, 16'd1, 8'h5A);
        add_vec("start_and_abort", 0, 1, 1, 0, 0, 16'h0000, S_IDLE, 0, 16'd1, 8'h5A);
        add_vec("restart",         0, 1, 0, 0, 0, 16'h0000, S_ARM,  0, 16'd0, 8'h5A);
        add_vec("abort_in_arm",    0, 0, 1, 0, 0, 16'h0000, S_IDLE, 0, 16'd0, 8'h5A);

        foreach (tbl[i]) begin
            areset = tbl[i].rst; start = tbl[i].st; abort = tbl[i].ab;
            adc_tvalid = tbl[i].tv; adc_tlast = tbl[i].tl; cur_adc = tbl[i].adc;
            tick();
            expect_out(tbl[i].name, tbl[i].e_state, tbl[i].e_done, 1'b0, tbl[i].e_bd);
            chk({tbl[i].name, "_lim"}, 32'(adc_limiter), 32'(tbl[i].e_lim));
        end
        quiet();

        // Three bursts separated by a 10-cycle holdoff.
        do_reset();
        cfg_bursts = 16'd3; cfg_holdoff = CW'(10); cfg_trigger_level = 16'h00FF; cur_adc = 16'h0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("ho_arm", S_ARM, 1'b0, 1'b0, 16'd0);
        for (int b = 0; b < 3; b++) begin
            wait_state(S_CAP, 30, "ho_capture");
            adc_tvalid = 1'b1; adc_tlast = 1'b1;
            tick();
            adc_tvalid = 1'b0; adc_tlast = 1'b0;
            if (b < 2) begin
                expect_out("ho_enter", S_HOLD, 1'b0, 1'b0, 16'(b + 1));
                n = 0; rt_seen = 1'b0;
                while (state === S_HOLD && n < 40) begin
                    rt_seen |= adc_reset_trigger;
                    n++;
                    tick();
                end
                chk("ho_len", 32'(n), 32'd10);
                chk("ho_rt_low", 32'(rt_seen), 32'd0);
                chk("ho_exit", 32'(state), 32'(S_WAIT));
            end else begin
                expect_out("ho_done", S_DONE, 1'b1, 1'b0, 16'd3);
                tick();
                expect_out("ho_idle", S_IDLE, 1'b0, 1'b0, 16'd3);
            end
        end

        // Level equality held for 100 cycles must not trigger.
        do_reset();
        cfg_bursts = 16'd1; cfg_holdoff = '0; cfg_trigger_level = 16'h0200; cur_adc = 16'h0200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        expect_out("eq_wait", S_WAIT, 1'b0, 1'b0, 16'd0);
        left_wait = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (state !== S_WAIT) left_wait = 1'b1;
        end
        chk("eq_held_100", 32'(left_wait), 32'd0);
        cur_adc = 16'h0201;
        tick();
        expect_out("eq_plus_one", S_CAP, 1'b0, 1'b0, 16'd0);
        adc_tvalid = 1'b1; adc_tlast = 1'b1;
        tick();
        quiet();
        expect_out("eq_done", S_DONE, 1'b1, 1'b0, 16'd1);

        // Continuous mode, start while busy, abort colliding with tlast.
        do_reset();
        cfg_bursts = 16'd0; cfg_holdoff = '0; cfg_trigger_level = 16'h00FF; cur_adc = 16'h0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(S_CAP, 10, "ab_capture");
        adc_tvalid = 1'b1; adc_tlast = 1'b1;
        tick();
        adc_tvalid = 1'b0; adc_tlast = 1'b0;
        expect_out("ab_burst1", S_WAIT, 1'b0, 1'b0, 16'd1);
        tick();
        expect_out("ab_recapture", S_CAP, 1'b0, 1'b0, 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("ab_start_busy", S_CAP, 1'b0, 1'b0, 16'd1);
        abort = 1'b1; adc_tvalid = 1'b1; adc_tlast = 1'b1;
        tick();
        quiet();
        expect_out("ab_abort_tlast", S_IDLE, 1'b0, 1'b0, 16'd1);
        tick();
        expect_out("ab_no_done", S_IDLE, 1'b0, 1'b0, 16'd1);

        // Trigger-wait timeout.
        do_reset();
        cfg_bursts = 16'd1; cfg_trigger_level = 16'hFFFF; cur_adc = 16'h0000; cfg_timeout = CW'(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        expect_out("to_wait", S_WAIT, 1'b0, 1'b0, 16'd0);
`ifdef ADC_SEQ_TIMEOUT_EN
        n = 0;
        while (state === S_WAIT && n < 200) begin
            n++;
            tick();
        end
        chk("to_wait_len", 32'(n), 32'd50);
        expect_out("to_done", S_DONE, 1'b1, 1'b1, 16'd0);
        tick();
        expect_out("to_sticky1", S_IDLE, 1'b0, 1'b1, 16'd0);
        tick();
        expect_out("to_sticky2", S_IDLE, 1'b0, 1'b1, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("to_cleared", S_ARM, 1'b0, 1'b0, 16'd0);
`else
        repeat (200) tick();
        expect_out("to_persist", S_WAIT, 1'b0, 1'b0, 16'd0);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("to_abort", S_IDLE, 1'b0, 1'b0, 16'd0);
        cfg_timeout = '0;

        // Reset in the middle of a capture.
        cfg_bursts = 16'd2; cfg_limiter = 8'hC3; cfg_trigger_level = 16'h0010; cur_adc = 16'h0020;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(S_CAP, 10, "rst_capture");
        areset = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        quiet();
        expect_out("rst_outputs", S_IDLE, 1'b0, 1'b0, 16'd0);
        chk("rst_lim", 32'(adc_limiter), 32'd0);
        tick();
        expect_out("rst_stays_idle", S_IDLE, 1'b0, 1'b0, 16'd0);

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            rand_session(s);
            quiet();
            adc_tvalid = 1'($urandom); adc_tlast = 1'($urandom); cur_adc = 16'($urandom);
            tick();
            adc_tvalid = 1'b0; adc_tlast = 1'b0;
            chk($sformatf("rnd%0d_idle_gap", s), 32'(state), 32'(S_IDLE));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
